multicycle_ctrl_fsm: RTL



---
 rtl/multicycle_ctrl_fsm.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the multicycle RV32I core: fetch/decode/execute/memory/writeback sequencing.
// Build option MC_ILLEGAL_TRAP_EN: unknown opcodes trap (held until reset) instead of being skipped as NOPs.
module multicycle_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pcwrite,
    output logic             adrsrc,
    output logic             memwrite,
    output logic             irwrite,
    output logic [1:0]       resultsrc,
    output logic [1:0]       alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       immsrc,
    output logic [1:0]       aluop,
    output logic             regwrite,
    output logic [CNT_W-1:0] instret,
    output logic             illegal_instr,
    output logic [3:0]       dbg_state
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_JAL      = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    typedef struct packed {
        logic       adrsrc;
        logic       memwrite;
        logic       regwrite;
        logic       fetch;
        logic       jump;
        logic       branch;
        logic       illegal;
        logic [1:0] resultsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
    } ctrl_t;

    state_t           r_state;
    state_t           w_next;
    ctrl_t            r_ctrl;
    logic [CNT_W-1:0] r_instret;
    logic             w_retire;
    logic             w_pcupdate;

    // Moore decode, applied to the next state so the outputs come straight from flops.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.fetch     = 1'b1;
                c.alusrcb   = 2'b10;
                c.resultsrc = 2'b10;
            end
            S_DECODE: begin
                c.alusrca = 2'b01;
                c.alusrcb = 2'b01;
            end
            S_MEMADR: begin
                c.alusrca = 2'b10;
                c.alusrcb = 2'b01;
            end
            S_MEMREAD:  c.adrsrc = 1'b1;
            S_MEMWB: begin
                c.resultsrc = 2'b01;
                c.regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adrsrc   = 1'b1;
                c.memwrite = 1'b1;
            end
            S_EXECUTER: begin
                c.alusrca = 2'b10;
                c.aluop   = 2'b10;
            end
            S_EXECUTEI: begin
                c.alusrca = 2'b10;
                c.alusrcb = 2'b01;
                c.aluop   = 2'b11;
            end
            S_JAL: begin
                c.alusrca = 2'b01;
                c.alusrcb = 2'b10;
                c.jump    = 1'b1;
            end
            S_ALUWB:    c.regwrite = 1'b1;
            S_BEQ: begin
                c.alusrca = 2'b10;
                c.aluop   = 2'b01;
                c.branch  = 1'b1;
            end
            S_TRAP:     c.illegal = 1'b1;
            default:    c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXECUTER;
                    OP_ITYPE:          w_next = S_EXECUTEI;
                    OP_JAL:            w_next = S_JAL;
                    OP_BEQ:            w_next = S_BEQ;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:           w_next = S_TRAP;
`else
                    default:           w_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   w_next = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) w_next = S_FETCH;
            S_EXECUTER: w_next = S_ALUWB;
            S_EXECUTEI: w_next = S_ALUWB;
            S_JAL:      w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BEQ:      w_next = S_FETCH;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_FETCH;
        endcase
    end

    // A DECODE->FETCH NOP skip is deliberately not a retirement.
    assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) || (r_state == S_BEQ) ||
                      ((r_state == S_MEMWRITE) && mem_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_ctrl    <= decode(S_FETCH);
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= decode(w_next);
            if (w_retire) r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        case (opcode)
            OP_LOAD, OP_ITYPE: immsrc = 2'b00;
            OP_STORE:          immsrc = 2'b01;
            OP_BEQ:            immsrc = 2'b10;
            OP_JAL:            immsrc = 2'b11;
            default:           immsrc = 2'b00;
        endcase
    end

    // Strobes are masked by rst so a mid-instruction reset issues no writes.
    assign w_pcupdate    = (r_ctrl.fetch & mem_ready) | r_ctrl.jump;
    assign pcwrite       = ~rst & (w_pcupdate | (r_ctrl.branch & zero));
    assign irwrite       = ~rst & r_ctrl.fetch & mem_ready;
    assign memwrite      = ~rst & r_ctrl.memwrite;
    assign regwrite      = ~rst & r_ctrl.regwrite;
    assign adrsrc        = r_ctrl.adrsrc;
    assign resultsrc     = r_ctrl.resultsrc;
    assign alusrca       = r_ctrl.alusrca;
    assign alusrcb       = r_ctrl.alusrcb;
    assign aluop         = r_ctrl.aluop;
    assign illegal_instr = r_ctrl.illegal;
    assign instret       = r_instret;
    assign dbg_state     = r_state;

endmodule
